// File: rtl/ltc2308_responder_pkg.sv
// ltc2308_emu_pkg: shared FSM states, default sizes, config bit positions and register addresses
package ltc2308_emu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, SHIFT = 2'd2} state_t;
  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_CFG_W = 6;
  localparam int CFG_SD = 5;
  localparam int CFG_OS = 4;
  localparam int CFG_S1 = 3;
  localparam int CFG_S0 = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;
  localparam logic [3:0] ADDR_STATUS = 4'd8;
endpackage

// File: rtl/ltc2308_responder_if.sv
// ltc2308_responder_if: ADC serial pins (convst/sck/sdi/sdo) and Avalon-MM register port; master = initiator/host, slave = responder
interface ltc2308_responder_if;
  logic adc_convst;
  logic adc_sck;
  logic adc_sdi;
  logic adc_sdo;
  logic [3:0] avs_address;
  logic avs_write;
  logic [31:0] avs_writedata;
  logic avs_read;
  logic [31:0] avs_readdata;
  modport master (
    output adc_convst, adc_sck, adc_sdi, avs_address, avs_write, avs_writedata, avs_read,
    input adc_sdo, avs_readdata
  );
  modport slave (
    input adc_convst, adc_sck, adc_sdi, avs_address, avs_write, avs_writedata, avs_read,
    output adc_sdo, avs_readdata
  );
endinterface

// File: rtl/ltc2308_responder_sync_edge.sv
// sync_edge: STAGES-deep synchronizer plus history flop; ports clk, reset_n, d in; level, rise/fall 1-cycle pulses out
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic hist;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s <= '0;
      hist <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      hist <= s[STAGES-1];
    end
  end
  assign level = s[STAGES-1];
  assign rise = level & ~hist;
  assign fall = ~level & hist;
endmodule

// File: rtl/ltc2308_responder.sv
// ltc2308_responder: LTC2308 serial-side emulator; ports clk, reset_n (sync active-low), bus (ADC pins + Avalon-MM sample/status regs)
module ltc2308_responder #(
  parameter int NUM_CH = ltc2308_emu_pkg::DEF_NUM_CH,
  parameter int DATA_W = ltc2308_emu_pkg::DEF_DATA_W,
  parameter int CFG_W = ltc2308_emu_pkg::DEF_CFG_W,
  parameter int SYNC_STAGES = 2,
  parameter bit RAMP_EN = 1'b0
) (
  input logic clk,
  input logic reset_n,
  ltc2308_responder_if.slave bus
);
  import ltc2308_emu_pkg::*;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CFG_END = CW'(CFG_W);
  localparam logic [CW-1:0] DATA_END = CW'(DATA_W);
  localparam logic [3:0] NCH = 4'(NUM_CH);
  state_t state, state_n;
  logic cv_rise, cv_fall, sck_rise, sck_fall, sdi;
  logic [3:0] edge_unused;
  logic load, start_sh, cfg_in, cnt_inc, shift, done, in_shift;
  logic [DATA_W-1:0] out_sr;
  logic [CFG_W-1:0] cfg_sr;
  logic [CW-1:0] bit_cnt;
  logic [2:0] active_ch;
  logic err;
  logic [15:0] frame_count;
  logic [DATA_W-1:0] sample [NUM_CH];
  sync_edge #(.STAGES(SYNC_STAGES)) u_convst (
    .clk, .reset_n, .d(bus.adc_convst), .level(edge_unused[0]), .rise(cv_rise), .fall(cv_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk, .reset_n, .d(bus.adc_sck), .level(edge_unused[1]), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (
    .clk, .reset_n, .d(bus.adc_sdi), .level(sdi), .rise(edge_unused[2]), .fall(edge_unused[3])
  );
  always_comb begin
    load = cv_rise;
    in_shift = state == SHIFT && !cv_rise;
    start_sh = state == CONVERT && !cv_rise && cv_fall;
    cfg_in = in_shift && sck_rise && bit_cnt < CFG_END;
    cnt_inc = in_shift && sck_rise && bit_cnt < DATA_END;
    shift = in_shift && sck_fall && bit_cnt < DATA_END;
    done = in_shift && sck_fall && bit_cnt == DATA_END;
    state_n = load ? CONVERT : start_sh ? SHIFT : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      out_sr <= '0;
      cfg_sr <= '0;
      bit_cnt <= '0;
      active_ch <= '0;
      err <= 1'b0;
      frame_count <= '0;
      sample <= '{default: '0};
      bus.adc_sdo <= 1'b0;
      bus.avs_readdata <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        out_sr <= sample[active_ch];
        bit_cnt <= '0;
        cfg_sr <= '0;
      end
      if (load && RAMP_EN) sample[active_ch] <= sample[active_ch] + 1'b1;
      if (start_sh) bus.adc_sdo <= out_sr[DATA_W-1];
      if (cfg_in) cfg_sr <= {cfg_sr[CFG_W-2:0], sdi};
      if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
      if (shift) begin
        out_sr <= out_sr << 1;
        bus.adc_sdo <= out_sr[DATA_W-2];
      end
      if (done) begin
        bus.adc_sdo <= 1'b0;
        frame_count <= frame_count + 1'b1;
        if (cfg_sr[CFG_SD]) active_ch <= {cfg_sr[CFG_S1], cfg_sr[CFG_S0], cfg_sr[CFG_OS]};
        else err <= 1'b1;
      end
      if (bus.avs_write && bus.avs_address < NCH) sample[bus.avs_address[2:0]] <= bus.avs_writedata[DATA_W-1:0];
      if (bus.avs_write && bus.avs_address == ADDR_STATUS && bus.avs_writedata[31]) err <= 1'b0;
      if (bus.avs_read)
        bus.avs_readdata <= bus.avs_address < NCH ? 32'(sample[bus.avs_address[2:0]]) :
                            bus.avs_address == ADDR_STATUS ? {err, 9'd0, frame_count, 1'b0, state, active_ch} : 32'd0;
    end
  end
endmodule

// File: tb/tb_ltc2308_responder.sv
// tb_ltc2308_responder: scoreboard bench driving a plain and a ramping responder with identical pin and bus stimulus
module tb_ltc2308_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  ltc2308_responder_if b0();
  ltc2308_responder_if b1();
  assign b1.adc_convst = b0.adc_convst;
  assign b1.adc_sck = b0.adc_sck;
  assign b1.adc_sdi = b0.adc_sdi;
  assign b1.avs_address = b0.avs_address;
  assign b1.avs_write = b0.avs_write;
  assign b1.avs_writedata = b0.avs_writedata;
  assign b1.avs_read = b0.avs_read;
  ltc2308_responder #(.RAMP_EN(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
  ltc2308_responder #(.RAMP_EN(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
  localparam int H = 5;
  int checks = 0;
  int errors = 0;
  logic [11:0] m_smp [2][8];
  logic [2:0] m_ch;
  logic m_err;
  logic [15:0] m_fc;
  logic [11:0] q0[$], q1[$];
  logic [31:0] rq0[$], rq1[$];
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] m_rd(int k, logic [3:0] a);
    return a < 4'd8 ? 32'(m_smp[k][a[2:0]]) :
           a == 4'd8 ? {m_err, 9'd0, m_fc, 1'b0, 2'b00, m_ch} : 32'd0;
  endfunction
  task automatic m_reset();
    for (int k = 0; k < 2; k++) for (int c = 0; c < 8; c++) m_smp[k][c] = 12'd0;
    m_ch = 3'd0;
    m_err = 1'b0;
    m_fc = 16'd0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(logic [3:0] a, logic [31:0] d);
    @(negedge clk);
    b0.avs_address = a;
    b0.avs_writedata = d;
    b0.avs_write = 1'b1;
    @(negedge clk);
    b0.avs_write = 1'b0;
    if (a < 4'd8) begin
      m_smp[0][a[2:0]] = d[11:0];
      m_smp[1][a[2:0]] = d[11:0];
    end else if (a == 4'd8 && d[31]) m_err = 1'b0;
  endtask
  task automatic rd(logic [3:0] a);
    @(negedge clk);
    rq0.push_back(m_rd(0, a));
    rq1.push_back(m_rd(1, a));
    b0.avs_address = a;
    b0.avs_read = 1'b1;
    @(negedge clk);
    b0.avs_read = 1'b0;
  endtask
  task automatic frame(logic [5:0] cfg, int nsck, int wa = -1, logic [11:0] wd = 12'd0);
    if (nsck == 12) begin
      q0.push_back(m_smp[0][m_ch]);
      q1.push_back(m_smp[1][m_ch]);
    end
    m_smp[1][m_ch] = m_smp[1][m_ch] + 12'd1;
    if (wa >= 0 && wa < 8) begin
      m_smp[0][wa] = wd;
      m_smp[1][wa] = wd;
    end
    @(negedge clk);
    b0.adc_convst = 1'b1;
    idle(2);
    if (wa >= 0) begin
      b0.avs_address = 4'(wa);
      b0.avs_writedata = 32'(wd);
      b0.avs_write = 1'b1;
    end
    idle(1);
    b0.avs_write = 1'b0;
    idle(2);
    b0.adc_convst = 1'b0;
    idle(H);
    for (int i = 0; i < nsck; i++) begin
      b0.adc_sdi = i < 6 ? cfg[5 - i] : 1'b0;
      idle(H);
      b0.adc_sck = 1'b1;
      idle(H);
      b0.adc_sck = 1'b0;
    end
    idle(H);
    if (nsck == 12) begin
      chk("sdo_after_frame0", 32'(b0.adc_sdo), 32'd0);
      chk("sdo_after_frame1", 32'(b1.adc_sdo), 32'd0);
      m_fc = m_fc + 16'd1;
      if (cfg[5]) m_ch = {cfg[3], cfg[2], cfg[4]};
      else m_err = 1'b1;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    b0.adc_convst = 1'b0;
    b0.adc_sck = 1'b0;
    idle(3);
    reset_n = 1'b1;
    m_reset();
  endtask
  initial begin : sdo_mon
    int cnt;
    logic [11:0] w0, w1;
    cnt = 0;
    w0 = '0;
    w1 = '0;
    forever begin
      @(posedge b0.adc_convst or posedge b0.adc_sck);
      if (b0.adc_convst) begin
        cnt = 0;
        w0 = '0;
        w1 = '0;
      end else begin
        w0 = {w0[10:0], b0.adc_sdo};
        w1 = {w1[10:0], b1.adc_sdo};
        cnt++;
        if (cnt == 12) begin
          if (q0.size() == 0 || q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sdo_word unexpected got=%h/%h exp=none", w0, w1);
          end else begin
            chk("sdo_word0", 32'(w0), 32'(q0.pop_front()));
            chk("sdo_word1", 32'(w1), 32'(q1.pop_front()));
          end
        end
      end
    end
  end
  initial begin : rd_mon
    forever begin
      @(posedge clk);
      if (b0.avs_read) begin
        @(negedge clk);
        if (rq0.size() == 0 || rq1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL readdata unexpected got=%h exp=none", b0.avs_readdata);
        end else begin
          chk("readdata0", b0.avs_readdata, rq0.pop_front());
          chk("readdata1", b1.avs_readdata, rq1.pop_front());
        end
      end
    end
  end
  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [5:0] cfg;
    b0.adc_convst = 1'b0;
    b0.adc_sck = 1'b0;
    b0.adc_sdi = 1'b0;
    b0.avs_address = '0;
    b0.avs_write = 1'b0;
    b0.avs_writedata = '0;
    b0.avs_read = 1'b0;
    m_reset();
    idle(4);
    reset_n = 1'b1;
    rd(4'd8);
    frame(6'b100010, 12);
    rd(4'd8);
    wr(4'd0, 32'hA5C);
    frame(6'b100010, 12);
    rd(4'd8);
    wr(4'd5, 32'h3F1);
    frame(6'b110110, 12);
    frame(6'b110110, 12);
    rd(4'd8);
    frame(6'b010110, 12);
    rd(4'd8);
    wr(4'd8, 32'h8000_0000);
    rd(4'd8);
    frame(6'b100010, 4);
    frame(6'b100010, 12);
    rd(4'd8);
    wr(4'd2, 32'hFFF);
    frame(6'b101010, 12);
    frame(6'b101010, 12);
    frame(6'b101010, 12);
    frame(6'b101010, 12, 2, 12'h123);
    rd(4'd2);
    idle(3);
    chk("readdata_hold", b0.avs_readdata, m_rd(0, 4'd2));
    rd(4'd11);
    frame(6'b100010, 5);
    do_reset();
    rd(4'd8);
    rd(4'd2);
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: wr(4'($urandom_range(0, 15)), $urandom);
        1: rd(4'($urandom_range(0, 15)));
        2: begin
          cfg = 6'($urandom);
          if ($urandom_range(0, 7) != 0) cfg[5] = 1'b1;
          frame(cfg, 12);
          rd(4'd8);
        end
        default: begin
          frame(6'($urandom), $urandom_range(1, 11));
          cfg = 6'($urandom);
          cfg[5] = 1'b1;
          frame(cfg, 12);
          rd(4'd8);
        end
      endcase
    end
    idle(10);
    chk("leftover_expectations", 32'(q0.size() + q1.size() + rq0.size() + rq1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
